// File: rtl/tlc_phase_scheduler_if.sv
// tlc_phase_scheduler_if: detector and request inputs plus lamp
// outputs of the intersection phase scheduler.
interface tlc_phase_scheduler_if;
  logic Sa;
  logic Sb;
  logic ped_req;
  logic emg_req;
  logic Ga;
  logic Ya;
  logic Ra;
  logic Gb;
  logic Yb;
  logic Rb;
  logic walk;
  logic ped_ack;

  modport master (
    output Sa, Sb, ped_req, emg_req,
    input  Ga, Ya, Ra, Gb, Yb, Rb, walk, ped_ack
  );

  modport slave (
    input  Sa, Sb, ped_req, emg_req,
    output Ga, Ya, Ra, Gb, Yb, Rb, walk, ped_ack
  );
endinterface

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: shares green time between street B, pedestrians
// and emergency pre-emption; street A green by default.
module tlc_phase_scheduler #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned A_MIN    = 5,
  parameter int unsigned B_MIN    = 4,
  parameter int unsigned B_MAX    = 8,
  parameter int unsigned YEL      = 2,
  parameter int unsigned ALLRED   = 1,
  parameter int unsigned WALK     = 4
) (
  input logic clk,
  input logic reset,
  tlc_phase_scheduler_if.slave bus
);
  localparam int unsigned PSC_W = $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
  localparam logic [4:0] T_AMIN = 5'(A_MIN);
  localparam logic [4:0] T_BMIN = 5'(B_MIN);
  localparam logic [4:0] T_BMAX = 5'(B_MAX);
  localparam logic [4:0] T_YEL  = 5'(YEL);
  localparam logic [4:0] T_AR   = 5'(ALLRED);
  localparam logic [4:0] T_WALK = 5'(WALK);

  typedef enum logic [2:0] {
    AG = 3'd0,
    AY = 3'd1,
    AR = 3'd2,
    BG = 3'd3,
    BY = 3'd4,
    PW = 3'd5,
    BR = 3'd6
  } state_t;

  typedef enum logic {
    GNT_B   = 1'b0,
    GNT_PED = 1'b1
  } grant_t;

  state_t state;
  state_t state_d;
  grant_t grant;
  grant_t grant_d;
  grant_t last_grant;
  grant_t last_grant_d;

  logic [PSC_W-1:0] psc;
  logic [3:0] timer;
  logic [4:0] elapsed;
  logic tick;
  logic entry;
  logic b_ext;
  logic ped_pending;
  logic a_ok;
  logic b_min_ok;
  logic b_max_ok;
  logic yel_done;
  logic ar_done;
  logic walk_done;
  logic [6:0] lamp_d;
  logic [6:0] lamp_q;
  logic ack_q;

  // elapsed counts the tick completing on this edge
  assign tick      = psc == PSC_LAST;
  assign elapsed   = {1'b0, timer} + 5'd1;
  assign entry     = state_d != state;
  assign b_ext     = bus.Sb & ~bus.Sa;
  assign a_ok      = tick && (elapsed >= T_AMIN);
  assign b_min_ok  = tick && (elapsed >= T_BMIN);
  assign b_max_ok  = tick && (elapsed >= T_BMAX);
  assign yel_done  = tick && (elapsed >= T_YEL);
  assign ar_done   = tick && (elapsed >= T_AR);
  assign walk_done = tick && (elapsed >= T_WALK);

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    unique case (state)
      AG: begin
        if (a_ok && (bus.Sb || ped_pending) && !bus.emg_req) begin
          state_d = AY;
          if (bus.Sb && ped_pending)
            grant_d = (last_grant == GNT_PED) ? GNT_B : GNT_PED;
          else
            grant_d = bus.Sb ? GNT_B : GNT_PED;
        end
      end
      AY: if (yel_done) state_d = AR;
      AR: begin
        if (ar_done) begin
          if (bus.emg_req) begin
            state_d = BR;
          end else begin
            state_d      = (grant == GNT_B) ? BG : PW;
            last_grant_d = grant;
          end
        end
      end
      BG: begin
        if (bus.emg_req || b_max_ok || (b_min_ok && !b_ext))
          state_d = BY;
      end
      BY: if (yel_done) state_d = BR;
      PW: if (bus.emg_req || walk_done) state_d = BR;
      BR: if (ar_done) state_d = AG;
      default: begin
        state_d = AR;
        grant_d = GNT_B;
      end
    endcase
  end

  // lamp order: Ga Ya Ra Gb Yb Rb walk
  always_comb begin
    lamp_d = 7'b0010010;
    unique case (state_d)
      AG: lamp_d = 7'b1000010;
      AY: lamp_d = 7'b0100010;
      AR: lamp_d = 7'b0010010;
      BG: lamp_d = 7'b0011000;
      BY: lamp_d = 7'b0010100;
      PW: lamp_d = 7'b0010011;
      BR: lamp_d = 7'b0010010;
      default: lamp_d = 7'b0010010;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= AG;
      grant       <= GNT_B;
      last_grant  <= GNT_PED;
      psc         <= '0;
      timer       <= '0;
      ped_pending <= 1'b0;
      lamp_q      <= 7'b1000010;
      ack_q       <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      if (entry) begin
        psc   <= '0;
        timer <= '0;
      end else if (tick) begin
        psc <= '0;
        if (timer != 4'hf)
          timer <= timer + 4'd1;
      end else begin
        psc <= psc + PSC_W'(1);
      end
      if (entry && state_d == PW)
        ped_pending <= 1'b0;
      else
        ped_pending <= ped_pending | bus.ped_req;
      lamp_q <= lamp_d;
      ack_q  <= entry && (state_d == PW);
    end
  end

  assign {bus.Ga, bus.Ya, bus.Ra} = lamp_q[6:4];
  assign {bus.Gb, bus.Yb, bus.Rb} = lamp_q[3:1];
  assign bus.walk    = lamp_q[0];
  assign bus.ped_ack = ack_q;
endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb_tlc_phase_scheduler: vector table, directed corner sequences and a
// random run against a cycle-counting reference model.
module tb_tlc_phase_scheduler;
  localparam int TICK_DIV = 4;
  localparam int A_MIN    = 5;
  localparam int B_MIN    = 4;
  localparam int B_MAX    = 8;
  localparam int YEL      = 2;
  localparam int ALLRED   = 1;
  localparam int WALK     = 4;

  localparam logic [6:0] L_AG = 7'b1000010;
  localparam logic [6:0] L_AY = 7'b0100010;
  localparam logic [6:0] L_AR = 7'b0010010;
  localparam logic [6:0] L_BG = 7'b0011000;
  localparam logic [6:0] L_BY = 7'b0010100;
  localparam logic [6:0] L_PW = 7'b0010011;
  localparam logic [6:0] L_BR = 7'b0010010;

  typedef enum int {M_AG, M_AY, M_AR, M_BG, M_BY, M_PW, M_BR} ph_t;

  typedef struct {
    string      nm;
    bit         sb;
    int         at;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  tlc_phase_scheduler_if ifc();

  tlc_phase_scheduler #(
    .TICK_DIV(TICK_DIV), .A_MIN(A_MIN), .B_MIN(B_MIN), .B_MAX(B_MAX),
    .YEL(YEL), .ALLRED(ALLRED), .WALK(WALK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk = 0;
  int cyc_n = 0;
  bit gb_any;

  ph_t m_ph;
  int m_cyc;
  bit m_pend;
  bit m_gr_b;
  bit m_last_b;
  bit m_ack;
  logic [6:0] lamp_tab [7];

  function automatic logic [6:0] lamps();
    return {ifc.Ga, ifc.Ya, ifc.Ra, ifc.Gb, ifc.Yb, ifc.Rb, ifc.walk};
  endfunction

  function automatic bit inv_ok();
    bit a_go, b_go;
    a_go = ifc.Ga | ifc.Ya;
    b_go = ifc.Gb | ifc.Yb;
    return !(a_go && b_go) && (!ifc.walk || (ifc.Ra && ifc.Rb));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic model_reset();
    m_ph = M_AG;
    m_cyc = 0;
    m_pend = 1'b0;
    m_gr_b = 1'b1;
    m_last_b = 1'b0;
    m_ack = 1'b0;
  endtask

  // one clock edge of the reference: cycles since entry, ticks = cycles/div
  task automatic model_edge();
    int n, t;
    bit tk, sa, sb, emg;
    ph_t nx;
    n = m_cyc + 1;
    tk = (n % TICK_DIV) == 0;
    t = n / TICK_DIV;
    sa = ifc.Sa;
    sb = ifc.Sb;
    emg = ifc.emg_req;
    nx = m_ph;
    case (m_ph)
      M_AG: if (tk && t >= A_MIN && (sb || m_pend) && !emg) begin
        nx = M_AY;
        m_gr_b = sb && !(m_pend && m_last_b);
      end
      M_AY: if (tk && t >= YEL) nx = M_AR;
      M_AR: if (tk && t >= ALLRED) begin
        if (emg) nx = M_BR;
        else begin
          nx = m_gr_b ? M_BG : M_PW;
          m_last_b = m_gr_b;
        end
      end
      M_BG: if (emg || (tk && t >= B_MAX) ||
                (tk && t >= B_MIN && !(sb && !sa))) nx = M_BY;
      M_BY: if (tk && t >= YEL) nx = M_BR;
      M_PW: if (emg || (tk && t >= WALK)) nx = M_BR;
      M_BR: if (tk && t >= ALLRED) nx = M_AG;
      default: nx = M_AG;
    endcase
    m_ack = (nx == M_PW) && (m_ph != M_PW);
    m_pend = m_ack ? 1'b0 : (m_pend | ifc.ped_req);
    m_cyc = (nx != m_ph) ? 0 : n;
    m_ph = nx;
  endtask

  task automatic step();
    logic [7:0] g, e;
    model_edge();
    @(posedge clk);
    #1;
    cyc_n++;
    g = {lamps(), ifc.ped_ack};
    e = {lamp_tab[m_ph], m_ack};
    chk($sformatf("model@%0d", cyc_n), 32'(g), 32'(e));
    chk("invariant", 32'(inv_ok()), 32'd1);
    gb_any |= ifc.Gb;
  endtask

  task automatic run_to(input int c);
    while (cyc_n < c) step();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("reset", 32'({lamps(), ifc.ped_ack}), 32'({L_AG, 1'b0}));
    @(negedge clk);
    reset = 1'b1;
    cyc_n = 0;
  endtask

  task automatic set_in(input bit sa, input bit sb, input bit ped,
                        input bit emg);
    ifc.Sa = sa;
    ifc.Sb = sb;
    ifc.ped_req = ped;
    ifc.emg_req = emg;
  endtask

  initial begin
    vec_t tab[$];
    int w;
    bit ok;

    lamp_tab[M_AG] = L_AG;
    lamp_tab[M_AY] = L_AY;
    lamp_tab[M_AR] = L_AR;
    lamp_tab[M_BG] = L_BG;
    lamp_tab[M_BY] = L_BY;
    lamp_tab[M_PW] = L_PW;
    lamp_tab[M_BR] = L_BR;

    tab.push_back('{"rel0",  1'b1,   0, L_AG});
    tab.push_back('{"ag19",  1'b1,  19, L_AG});
    tab.push_back('{"ay20",  1'b1,  20, L_AY});
    tab.push_back('{"ay27",  1'b1,  27, L_AY});
    tab.push_back('{"ar28",  1'b1,  28, L_AR});
    tab.push_back('{"ar31",  1'b1,  31, L_AR});
    tab.push_back('{"bg32",  1'b1,  32, L_BG});
    tab.push_back('{"bg63",  1'b1,  63, L_BG});
    tab.push_back('{"by64",  1'b1,  64, L_BY});
    tab.push_back('{"by71",  1'b1,  71, L_BY});
    tab.push_back('{"br72",  1'b1,  72, L_BR});
    tab.push_back('{"ag76",  1'b1,  76, L_AG});
    tab.push_back('{"ay96",  1'b1,  96, L_AY});
    tab.push_back('{"bg108", 1'b1, 108, L_BG});
    tab.push_back('{"bg123", 1'b0, 123, L_BG});
    tab.push_back('{"by124", 1'b0, 124, L_BY});

    set_in(0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // reset in the middle of a B green
    ifc.Sb = 1'b1;
    run_to(40);
    chk("pre_rst_bg", 32'(lamps()), 32'(L_BG));
    do_reset();

    foreach (tab[i]) begin
      ifc.Sb = tab[i].sb;
      run_to(tab[i].at);
      chk(tab[i].nm, 32'(lamps()), 32'(tab[i].exp));
    end

    // pedestrian alone
    set_in(0, 0, 0, 0);
    do_reset();
    gb_any = 1'b0;
    run_to(2);
    ifc.ped_req = 1'b1;
    step();
    ifc.ped_req = 1'b0;
    run_to(31);
    chk("ped_walk31", 32'(ifc.walk), 32'd0);
    step();
    chk("ped_walk32", 32'({ifc.walk, ifc.ped_ack}), 32'd3);
    step();
    chk("ped_ack33", 32'({ifc.walk, ifc.ped_ack}), 32'd2);
    run_to(47);
    chk("ped_walk47", 32'(lamps()), 32'(L_PW));
    step();
    chk("ped_br48", 32'(lamps()), 32'(L_BR));
    run_to(52);
    chk("ped_ag52", 32'(lamps()), 32'(L_AG));
    chk("ped_no_gb", 32'(gb_any), 32'd0);

    // B and pedestrian both pending: service alternates B, PED, B, PED
    set_in(0, 1, 0, 0);
    do_reset();
    ifc.ped_req = 1'b1;
    step();
    ifc.ped_req = 1'b0;
    for (int s = 0; s < 4; s++) begin
      w = 0;
      while (!(ifc.Gb || ifc.walk) && w < 300) begin
        step();
        w++;
      end
      chk($sformatf("svc%0d", s), 32'({ifc.Gb, ifc.walk}),
          (s % 2 == 1) ? 32'd1 : 32'd2);
      ifc.ped_req = 1'b1;
      step();
      ifc.ped_req = 1'b0;
      w = 0;
      while (!ifc.Ga && w < 300) begin
        step();
        w++;
      end
      chk($sformatf("svc%0d_back", s), 32'(ifc.Ga), 32'd1);
    end

    // emergency one cycle into B green
    set_in(0, 1, 0, 0);
    do_reset();
    run_to(32);
    chk("emg_bg32", 32'(lamps()), 32'(L_BG));
    ifc.emg_req = 1'b1;
    step();
    chk("emg_by33", 32'(lamps()), 32'(L_BY));
    run_to(40);
    chk("emg_by40", 32'(lamps()), 32'(L_BY));
    step();
    chk("emg_br41", 32'(lamps()), 32'(L_BR));
    run_to(44);
    chk("emg_br44", 32'(lamps()), 32'(L_BR));
    step();
    chk("emg_ag45", 32'(lamps()), 32'(L_AG));
    ok = 1'b1;
    repeat (40) begin
      step();
      ok &= ifc.Ga;
    end
    chk("emg_hold", 32'(ok), 32'd1);
    ifc.emg_req = 1'b0;
    w = 0;
    while (!ifc.Ya && w < 10) begin
      step();
      w++;
    end
    chk("emg_release", 32'(ifc.Ya), 32'd1);

    // random run against the reference model
    set_in(0, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 20000; k++) begin
      ifc.Sa = ($urandom % 10) < 3;
      ifc.Sb = ($urandom % 2) == 0;
      ifc.ped_req = ($urandom % 20) == 0;
      if (ifc.emg_req) ifc.emg_req = ($urandom % 20) != 0;
      else ifc.emg_req = ($urandom % 100) == 0;
      if (($urandom % 5000) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
